// File: rtl/sm_pkg.sv
// Shared constants and types for the control FSM and its error monitor.
// Holds FSM output codes, IRQ state encoding and an illegal-code helper.
package sm_pkg;

  localparam logic [2:0] OUT_IDLE  = 3'b000;
  localparam logic [2:0] OUT_S1    = 3'b100;
  localparam logic [2:0] OUT_S2    = 3'b010;
  localparam logic [2:0] OUT_ERROR = 3'b111;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_st_t;

  function automatic logic is_illegal(
    input logic [2:0] c
  );
    return !(c == OUT_IDLE || c == OUT_S1 ||
             c == OUT_S2   || c == OUT_ERROR);
  endfunction

endpackage

// File: rtl/sm_sat_cnt.sv
// Saturating up-counter, priority clr > zero > inc.
// Ports: clk, nrst (async low), clr, inc, zero, q[W-1:0].
module sm_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         inc,
  input  logic         zero,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q <= '0;
    end else if (clr || zero) begin
      q <= '0;
    end else if (inc && q != MAX) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/sm_err_monitor.sv
// Error monitor for the control FSM outputs {o1,o2,err}: counts err
// episodes, tracks run lengths, flags illegal codes, raises a level irq.
// Ports: clk, nrst, o1, o2, err, clr, irq_ack -> err_cnt, run_len,
//        max_len, ill_sticky, irq.
module sm_err_monitor
  import sm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             o1,
  input  logic             o2,
  input  logic             err,
  input  logic             clr,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] err_cnt,
  output logic [LEN_W-1:0] run_len,
  output logic [LEN_W-1:0] max_len,
  output logic             ill_sticky,
  output logic             irq
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic             err_d;
  logic             err_rise;
  logic             ill;
  logic             evt;
  logic [LEN_W-1:0] run_nxt;
  irq_st_t          st;
  irq_st_t          st_nxt;

  assign ill      = is_illegal({o1, o2, err});
  assign err_rise = err & ~err_d;
  assign evt      = err_rise | ill;

  sm_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .inc  (err_rise),
    .zero (1'b0),
    .q    (err_cnt)
  );

  sm_sat_cnt #(.W(LEN_W)) u_run (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .inc  (err),
    .zero (~err),
    .q    (run_len)
  );

  // Mirror of the run counter's next value so max_len
  // follows run_len within the same cycle.
  always_comb begin
    run_nxt = '0;
    if (err)
      run_nxt = (run_len == LEN_MAX) ? run_len
                                     : run_len + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_d      <= 1'b0;
      max_len    <= '0;
      ill_sticky <= 1'b0;
      st         <= IRQ_IDLE;
    end else begin
      err_d <= err;
      st    <= st_nxt;
      if (clr) begin
        max_len    <= '0;
        ill_sticky <= 1'b0;
      end else begin
        if (run_nxt > max_len)
          max_len <= run_nxt;
        if (ill)
          ill_sticky <= 1'b1;
      end
    end
  end

  // An ack coinciding with a fresh event keeps the request up.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IRQ_IDLE: if (evt) st_nxt = IRQ_PEND;
      IRQ_PEND: if (irq_ack && !evt) st_nxt = IRQ_IDLE;
    endcase
  end

  assign irq = (st == IRQ_PEND);

endmodule

// File: tb/tb_sm_err_monitor.sv
// Directed bench for sm_err_monitor (default widths and CNT_W=2).
// Both instances share stimulus; expected values are hand-computed.
module tb_sm_err_monitor;
  import sm_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] code = OUT_ERROR;
  logic       clr = 1'b0;
  logic       irq_ack = 1'b0;

  logic [7:0] a_cnt, a_run, a_max;
  logic       a_ill, a_irq;
  logic [1:0] b_cnt;
  logic [7:0] b_run, b_max;
  logic       b_ill, b_irq;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  sm_err_monitor u_a (
    .clk(clk), .nrst(nrst),
    .o1(code[2]), .o2(code[1]), .err(code[0]),
    .clr(clr), .irq_ack(irq_ack),
    .err_cnt(a_cnt), .run_len(a_run),
    .max_len(a_max), .ill_sticky(a_ill),
    .irq(a_irq)
  );

  sm_err_monitor #(.CNT_W(2)) u_b (
    .clk(clk), .nrst(nrst),
    .o1(code[2]), .o2(code[1]), .err(code[0]),
    .clr(clr), .irq_ack(irq_ack),
    .err_cnt(b_cnt), .run_len(b_run),
    .max_len(b_max), .ill_sticky(b_ill),
    .irq(b_irq)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d want %0d",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq [4];
  int         lens [3];

  initial begin
    // reset held with err=1 forced
    repeat (3) tick();
    chk("rst_cnt", a_cnt, 0);
    chk("rst_run", a_run, 0);
    chk("rst_max", a_max, 0);
    chk("rst_ill", a_ill, 0);
    chk("rst_irq", a_irq, 0);
    #2 nrst = 1'b1;
    tick();
    chk("first_cnt", a_cnt, 1);
    chk("first_irq", a_irq, 1);
    chk("first_run", a_run, 1);
    code = OUT_IDLE; irq_ack = 1'b1;
    tick();
    chk("ack0_irq", a_irq, 0);
    chk("ack0_max", a_max, 1);
    irq_ack = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr0_cnt", a_cnt, 0);
    chk("clr0_max", a_max, 0);

    // legal non-error walk
    seq[0] = OUT_IDLE; seq[1] = OUT_S1;
    seq[2] = OUT_S2;   seq[3] = OUT_IDLE;
    for (int i = 0; i < 4; i++) begin
      code = seq[i];
      tick();
      chk("walk_cnt", a_cnt, 0);
      chk("walk_irq", a_irq, 0);
      chk("walk_ill", a_ill, 0);
    end

    // three error episodes 2,5,3 with acks
    lens[0] = 2; lens[1] = 5; lens[2] = 3;
    for (int e = 0; e < 3; e++) begin
      code = OUT_ERROR;
      for (int c = 0; c < lens[e]; c++) begin
        tick();
        if (c == 0) chk("ep_irq", a_irq, 1);
      end
      chk("ep_run", a_run, lens[e]);
      code = OUT_IDLE;
      tick();
      chk("ep_run0", a_run, 0);
      chk("ep_irq_hold", a_irq, 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ep_irq_fall", a_irq, 0);
    end
    chk("ep_cnt", a_cnt, 3);
    chk("ep_cnt_b", b_cnt, 3);
    chk("ep_max", a_max, 5);
    chk("ep_run_end", a_run, 0);

    // illegal code, then clr
    code = 3'b101;
    tick();
    chk("ill_set", a_ill, 1);
    chk("ill_irq", a_irq, 1);
    code = OUT_IDLE; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ill", a_ill, 0);
    chk("clr_irq", a_irq, 1);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_max", a_max, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("clr_ack", a_irq, 0);

    // ack coinciding with a new rise
    code = OUT_ERROR;
    tick();
    code = OUT_IDLE;
    tick();
    chk("co_irq0", a_irq, 1);
    code = OUT_ERROR; irq_ack = 1'b1;
    tick();
    chk("co_irq", a_irq, 1);
    chk("co_cnt", a_cnt, 2);
    code = OUT_IDLE;
    tick();
    irq_ack = 1'b0;
    chk("co_fall", a_irq, 0);

    // persistent illegal code keeps irq up across ack
    code = 3'b110;
    tick();
    irq_ack = 1'b1;
    tick();
    chk("pers_irq", a_irq, 1);
    code = OUT_IDLE;
    tick();
    irq_ack = 1'b0;
    chk("pers_fall", a_irq, 0);

    // saturation on the 2-bit instance
    for (int e = 0; e < 5; e++) begin
      code = OUT_ERROR;
      tick();
      code = OUT_IDLE;
      tick();
    end
    chk("sat_a", a_cnt, 7);
    chk("sat_b", b_cnt, 3);

    // clr together with a rise drops the event
    code = OUT_ERROR; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrrise_a", a_cnt, 0);
    chk("clrrise_b", b_cnt, 0);
    chk("clrrise_run", a_run, 0);
    code = OUT_IDLE;
    tick();
    chk("clrrise_hold", a_cnt, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
